// File: rtl/autosym_eval_pipe.sv
// autosym_eval_pipe
//   Pipelined evaluator for autosymmetric Boolean functions f(x) = fr(z), with
//   z[j] = XOR(x & mask_j) and fr a K-input truth table. All CH channels share
//   one configuration (K masks + 2^K-bit table), which is loaded bit-serially.
//
//   Ports
//     clk, rst                 rising-edge clock, synchronous active-high reset
//     cfg_start                pulse: enter (re)configuration
//     cfg_bit_valid, cfg_bit   serial config stream, honoured in LOAD only
//     cfg_done                 registered pulse when the last config bit is taken
//     configured               high while in RUN
//     in_valid/in_ready/in_x   input handshake, channel c at in_x[c*N_IN +: N_IN]
//     out_valid/out_ready/out_y result handshake, channel c result on out_y[c]

// Per-channel datapath: S1 computes and registers z, S2 looks up the table.
module autosym_lane #(
  parameter int N_IN = 7,
  parameter int K    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     adv_i,
  input  logic [N_IN-1:0]          x_i,
  input  logic [K-1:0][N_IN-1:0]   masks_i,
  input  logic [2**K-1:0]          tt_i,
  output logic                     y_o
);
  logic [K-1:0] z_d, z_q;
  logic         y_q;

  always_comb begin
    z_d = '0;
    for (int j = 0; j < K; j++) z_d[j] = ^(x_i & masks_i[j]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= '0;
      y_q <= 1'b0;
    end else if (adv_i) begin
      z_q <= z_d;
      y_q <= tt_i[z_q];
    end
  end

  assign y_o = y_q;
endmodule

module autosym_eval_pipe #(
  parameter int N_IN = 7,
  parameter int K    = 4,
  parameter int CH   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic               cfg_bit_valid,
  input  logic               cfg_bit,
  output logic               cfg_done,
  output logic               configured,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH*N_IN-1:0] in_x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH-1:0]      out_y
);
  localparam int TT_W     = 2**K;
  localparam int CFG_BITS = K*N_IN + TT_W;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS - 1);

  typedef enum logic [1:0] {UNCFG, DRAIN, LOAD, RUN} state_e;

  state_e                  state_q;
  logic [CFG_BITS-1:0]     sr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    cfg_done_q, configured_q;
  logic                    s1_valid_q, out_valid_q;
  logic                    adv, xfer;
  logic [TT_W-1:0]         tt;
  logic [K-1:0][N_IN-1:0]  masks;

  // First bit sent ends up at the MSB: layout is {mask_K-1 .. mask_0, tt}.
  assign tt = sr_q[TT_W-1:0];
  for (genvar j = 0; j < K; j++) begin : g_mask
    assign masks[j] = sr_q[TT_W + j*N_IN +: N_IN];
  end

  // One global advance: the whole pipe freezes while a result is held.
  assign adv      = !out_valid_q || out_ready;
  // A cfg_start cycle never accepts input, so nothing slips in behind DRAIN.
  assign in_ready = (state_q == RUN) && adv && !cfg_start;
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= UNCFG;
      sr_q         <= '0;
      cnt_q        <= '0;
      cfg_done_q   <= 1'b0;
      configured_q <= 1'b0;
    end else begin
      cfg_done_q <= 1'b0;
      case (state_q)
        UNCFG: if (cfg_start) state_q <= DRAIN;
        RUN: if (cfg_start) begin
          state_q      <= DRAIN;
          configured_q <= 1'b0;
        end
        // Config only changes once the pipe is empty, so in-flight results
        // always use the configuration they were accepted under.
        DRAIN: if (!s1_valid_q && !out_valid_q) begin
          state_q <= LOAD;
          cnt_q   <= '0;
        end
        LOAD: begin
          if (cfg_start) begin
            cnt_q <= '0;
          end else if (cfg_bit_valid) begin
            sr_q <= {sr_q[CFG_BITS-2:0], cfg_bit};
            if (cnt_q == CNT_LAST) begin
              cnt_q        <= '0;
              cfg_done_q   <= 1'b1;
              configured_q <= 1'b1;
              state_q      <= RUN;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= UNCFG;
      endcase
    end
  end

  // Valid shift: bubbles travel with the data and are not collapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      s1_valid_q  <= xfer;
      out_valid_q <= s1_valid_q;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    autosym_lane #(.N_IN(N_IN), .K(K)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .adv_i   (adv),
      .x_i     (in_x[c*N_IN +: N_IN]),
      .masks_i (masks),
      .tt_i    (tt),
      .y_o     (out_y[c])
    );
  end

  assign cfg_done   = cfg_done_q;
  assign configured = configured_q;
  assign out_valid  = out_valid_q;
endmodule

// File: tb/tb_autosym_eval_pipe.sv
module tb_autosym_eval_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_start = 1'b0, cfg_bit_valid = 1'b0, cfg_bit = 1'b0;

  logic        in_valid_a = 1'b0, out_ready_a = 1'b1;
  logic [6:0]  in_x_a = '0;
  logic        in_ready_a, out_valid_a, cfg_done_a, configured_a;
  logic [0:0]  out_y_a;

  logic        in_valid_b = 1'b0, out_ready_b = 1'b1;
  logic [20:0] in_x_b = '0;
  logic        in_ready_b, out_valid_b, cfg_done_b, configured_b;
  logic [2:0]  out_y_b;

  int checks = 0, failures = 0, n_out = 0;
  logic exp_q[$];
  logic [6:0]  cur_m [4];
  logic [15:0] cur_tt;

  always #5 clk = ~clk;

  autosym_eval_pipe #(.N_IN(7), .K(4), .CH(1)) dut_a (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_bit_valid(cfg_bit_valid),
    .cfg_bit(cfg_bit), .cfg_done(cfg_done_a), .configured(configured_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_x(in_x_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_y(out_y_a));

  autosym_eval_pipe #(.N_IN(7), .K(4), .CH(3)) dut_b (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_bit_valid(cfg_bit_valid),
    .cfg_bit(cfg_bit), .cfg_done(cfg_done_b), .configured(configured_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_x(in_x_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_y(out_y_b));

  // Reference: z[j] = parity(x & mask_j), y = tt[z]
  function automatic logic model_y(input logic [6:0] x);
    logic [3:0] z;
    for (int j = 0; j < 4; j++) z[j] = ^(x & cur_m[j]);
    return cur_tt[z];
  endfunction

  function automatic logic [43:0] cfg_stream();
    return {cur_m[3], cur_m[2], cur_m[1], cur_m[0], cur_tt};
  endfunction

  // Scoreboard for instance A
  always @(negedge clk) begin
    if (!rst && out_valid_a && out_ready_a) begin
      logic e;
      checks++;
      n_out++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_extra: out_y=%0b delivered with no expected result", out_y_a);
      end else begin
        e = exp_q.pop_front();
        if (out_y_a !== e) begin
          failures++;
          $display("FAIL sb_data: out_y=%0b expected=%0b", out_y_a, e);
        end
      end
    end
  end

  task automatic cfg_restart();
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic send_bits(input logic [43:0] s, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      cfg_bit_valid = 1'b1;
      cfg_bit = s[43 - i];
      @(posedge clk); #1;
    end
    cfg_bit_valid = 1'b0;
  endtask

  task automatic send_a(input logic [6:0] x);
    bit ok = 0;
    in_valid_a = 1'b1;
    in_x_a = x;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (in_ready_a) begin
        exp_q.push_back(model_y(x));
        @(posedge clk); #1;
        ok = 1;
      end
    end
    in_valid_a = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout: x=%h not accepted, in_ready=%0b required 1", x, in_ready_a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    checks++;
    if ({in_ready_a, out_valid_a, out_y_a, configured_a, cfg_done_a} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 00000",
               {in_ready_a, out_valid_a, out_y_a, configured_a, cfg_done_a});
    end
    in_valid_a = 1'b1;
    in_x_a = 7'h0F;
    begin
      bit seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (out_valid_a || in_ready_a) seen = 1;
      end
      checks++;
      if (seen) begin
        failures++;
        $display("FAIL uncfg_ignore: out_valid/in_ready went 1, required 0");
      end
    end
    in_valid_a = 1'b0;
  endtask

  task automatic test_load();
    logic [43:0] s;
    cur_m[0] = 7'h01; cur_m[1] = 7'h02; cur_m[2] = 7'h04; cur_m[3] = 7'h18;
    cur_tt = 16'h8000;
    s = cfg_stream();
    cfg_restart();
    send_bits(s, 0, 43);
    checks++;
    if (cfg_done_a !== 1'b0 || configured_a !== 1'b0) begin
      failures++;
      $display("FAIL load_early: cfg_done=%0b configured=%0b required 0 0", cfg_done_a, configured_a);
    end
    send_bits(s, 43, 1);
    checks++;
    if (cfg_done_a !== 1'b1 || configured_a !== 1'b1 || in_ready_a !== 1'b1) begin
      failures++;
      $display("FAIL load_done: cfg_done=%0b configured=%0b in_ready=%0b required 1 1 1",
               cfg_done_a, configured_a, in_ready_a);
    end
    @(posedge clk); #1;
    checks++;
    if (cfg_done_a !== 1'b0 || configured_a !== 1'b1) begin
      failures++;
      $display("FAIL load_pulse: cfg_done=%0b configured=%0b required 0 1", cfg_done_a, configured_a);
    end
  endtask

  task automatic test_evaluate();
    send_a(7'h0F);
    checks++;
    if (out_valid_a !== 1'b0) begin
      failures++;
      $display("FAIL lat_early: out_valid=%0b required 0", out_valid_a);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid_a !== 1'b1 || out_y_a !== 1'b1) begin
      failures++;
      $display("FAIL lat_2: out_valid=%0b out_y=%0b required 1 1", out_valid_a, out_y_a);
    end
    send_a(7'h1F);
    send_a(7'h07);
    @(posedge clk); #1;
    checks++;
    if (out_valid_a !== 1'b1 || out_y_a !== 1'b0) begin
      failures++;
      $display("FAIL b2b_1F: out_valid=%0b out_y=%0b required 1 0", out_valid_a, out_y_a);
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain: pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int n0 = n_out;
    logic h;
    send_a(7'h0F);
    send_a(7'h1F);
    out_ready_a = 1'b0;
    fork
      begin send_a(7'h07); send_a(7'h0F); end
      begin
        h = out_y_a;
        checks++;
        if (out_valid_a !== 1'b1 || h !== 1'b1) begin
          failures++;
          $display("FAIL bp_head: out_valid=%0b out_y=%0b required 1 1", out_valid_a, h);
        end
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (out_valid_a !== 1'b1 || out_y_a !== h || in_ready_a !== 1'b0) begin
          failures++;
          $display("FAIL bp_hold: out_valid=%0b out_y=%0b in_ready=%0b required 1 %0b 0",
                   out_valid_a, out_y_a, in_ready_a, h);
        end
        out_ready_a = 1'b1;
      end
    join
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (n_out - n0 != 4 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_count: delivered=%0d pending=%0d required 4 0", n_out - n0, exp_q.size());
    end
  endtask

  task automatic test_reconfig();
    int n0 = n_out;
    logic [43:0] s;
    send_a(7'h0F);
    send_a(7'h1F);
    cfg_start = 1'b1;      // the vector offered alongside must be dropped
    in_valid_a = 1'b1;
    in_x_a = 7'h07;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    in_valid_a = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (n_out - n0 != 2 || exp_q.size() != 0 || configured_a !== 1'b0) begin
      failures++;
      $display("FAIL rc_drain: delivered=%0d pending=%0d configured=%0b required 2 0 0",
               n_out - n0, exp_q.size(), configured_a);
    end
    cur_tt = 16'h0001;
    s = cfg_stream();
    send_bits(s, 0, 10);
    cfg_restart();           // restart inside LOAD
    send_bits(s, 0, 43);
    checks++;
    if (configured_a !== 1'b0) begin
      failures++;
      $display("FAIL rc_restart: configured=%0b after 43 bits, required 0", configured_a);
    end
    send_bits(s, 43, 1);
    checks++;
    if (configured_a !== 1'b1 || cfg_done_a !== 1'b1) begin
      failures++;
      $display("FAIL rc_done: configured=%0b cfg_done=%0b required 1 1", configured_a, cfg_done_a);
    end
    send_a(7'h00);
    @(posedge clk); #1;
    checks++;
    if (out_valid_a !== 1'b1 || out_y_a !== 1'b1) begin
      failures++;
      $display("FAIL rc_eval00: out_valid=%0b out_y=%0b required 1 1", out_valid_a, out_y_a);
    end
    send_a(7'h0F);
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic test_multichannel();
    bit ok = 0;
    cur_tt = 16'h8000;
    cfg_restart();
    send_bits(cfg_stream(), 0, 44);
    in_valid_b = 1'b1;
    in_x_b = {7'h0F, 7'h1F, 7'h0F};
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (in_ready_b) begin @(posedge clk); #1; ok = 1; end
    end
    in_valid_b = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (!ok || out_valid_b !== 1'b1 || out_y_b !== 3'b101) begin
      failures++;
      $display("FAIL ch3_eval: accepted=%0b out_valid=%0b out_y=%b required 1 1 101",
               ok, out_valid_b, out_y_b);
    end
    cfg_restart();
    send_bits(cfg_stream(), 0, 10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({configured_b, configured_a, in_ready_b, out_valid_b, out_y_b, cfg_done_b} !== 8'b0) begin
      failures++;
      $display("FAIL rst_in_load: got %b required 00000000",
               {configured_b, configured_a, in_ready_b, out_valid_b, out_y_b, cfg_done_b});
    end
    send_bits(cfg_stream(), 10, 34);   // stray bits outside LOAD
    checks++;
    if (configured_b !== 1'b0 || cfg_done_b !== 1'b0) begin
      failures++;
      $display("FAIL stray_bits: configured=%0b cfg_done=%0b required 0 0", configured_b, cfg_done_b);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_evaluate();
    test_backpressure();
    test_reconfig();
    test_multichannel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
